// File: rtl/rgb_value_overlay_if.sv
// Control/result handshake of the RGB value overlay.
//   load        : one-cycle request to capture val_r/val_g/val_b and convert
//   val_r/g/b   : 8-bit channel values 0..255
//   busy        : conversion in progress
//   done        : one-cycle pulse when the new digits are committed
// master = requester side, slave = overlay side.
interface rgb_value_overlay_if;
    logic       load;
    logic [7:0] val_r;
    logic [7:0] val_g;
    logic [7:0] val_b;
    logic       busy;
    logic       done;

    modport master (output load, val_r, val_g, val_b, input busy, done);
    modport slave  (input load, val_r, val_g, val_b, output busy, done);
endinterface

// File: rtl/rgb_value_overlay.sv
// Renders three 8-bit channel values (R, G, B) as decimal text on a VGA scan.
// A load converts all three values to BCD in parallel (shift-add-3, one shift
// per clock); the nine displayed digits change only at commit, so the screen
// never shows a partial conversion. A two-stage pipeline maps the scan
// position to a glyph ROM request and then to a lit-pixel decision.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ctrl                : load/values in, busy/done out (slave modport)
//   hcount, vcount      : scan position, video_on : active-video flag
//   glyph_digit         : digit 0..9 selecting the external glyph ROM
//   glyph_row_addr      : glyph row 0..15
//   glyph_row           : addressed glyph row, bit 0 leftmost (combinational)
//   pixel_on, pixel_ch  : lit text pixel and its channel (0=R, 1=G, 2=B)
module rgb_value_overlay #(
    parameter logic [9:0] X0       = 10'd16,
    parameter logic [9:0] Y0       = 10'd16,
    parameter bit         BLANK_LZ = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    rgb_value_overlay_if.slave  ctrl,
    input  logic [9:0]          hcount,
    input  logic [9:0]          vcount,
    input  logic                video_on,
    output logic [3:0]          glyph_digit,
    output logic [3:0]          glyph_row_addr,
    input  logic [0:15]         glyph_row,
    output logic                pixel_on,
    output logic [1:0]          pixel_ch
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state, state_nxt;
    logic        start, busy, done;
    logic [2:0]  shift_cnt;
    // {hundreds, tens, units, binary} per channel
    logic [19:0] sh_r, sh_g, sh_b;
    // displayed digits [channel][position], position 0=hundreds, 2=units
    logic [2:0][2:0][3:0] dig;

    // One shift-add-3 iteration: correct each BCD nibble >= 5, then shift.
    function automatic logic [19:0] bcd_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        for (int unsigned i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5)
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl.load) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (shift_cnt == 3'd7) state_nxt = COMMIT;
            end
            COMMIT: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ctrl.busy = busy;
    assign ctrl.done = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt <= '0;
            sh_r      <= '0;
            sh_g      <= '0;
            sh_b      <= '0;
            dig       <= '0;
        end else begin
            if (start) begin
                sh_r      <= {12'd0, ctrl.val_r};
                sh_g      <= {12'd0, ctrl.val_g};
                sh_b      <= {12'd0, ctrl.val_b};
                shift_cnt <= '0;
            end else if (state == CONV) begin
                sh_r      <= bcd_step(sh_r);
                sh_g      <= bcd_step(sh_g);
                sh_b      <= bcd_step(sh_b);
                shift_cnt <= shift_cnt + 3'd1;
            end
            if (state == COMMIT) begin
                dig[0] <= {sh_r[11:8], sh_r[15:12], sh_r[19:16]};
                dig[1] <= {sh_g[11:8], sh_g[15:12], sh_g[19:16]};
                dig[2] <= {sh_b[11:8], sh_b[15:12], sh_b[19:16]};
            end
        end
    end

    // Scan decode; positions left of X0 / above Y0 wrap to large values
    // and fall outside the region test.
    logic [9:0] rel_x, rel_y;
    logic [1:0] line, pos;
    logic       in_region, blank;
    logic [3:0] sel_digit;

    assign rel_x     = hcount - X0;
    assign rel_y     = vcount - Y0;
    assign line      = rel_y[5:4];
    assign pos       = rel_x[5:4];
    assign in_region = video_on && (rel_x < 10'd48) && (rel_y < 10'd48);

    always_comb begin
        sel_digit = '0;
        blank     = 1'b0;
        if (in_region) begin
            sel_digit = dig[line][pos];
            if (BLANK_LZ) begin
                if (pos == 2'd0)
                    blank = (dig[line][0] == 4'd0);
                else if (pos == 2'd1)
                    blank = (dig[line][0] == 4'd0) && (dig[line][1] == 4'd0);
            end
        end
    end

    logic [3:0] col1;
    logic [1:0] ch1;
    logic       in1, blank1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glyph_digit    <= '0;
            glyph_row_addr <= '0;
            col1           <= '0;
            ch1            <= '0;
            in1            <= 1'b0;
            blank1         <= 1'b0;
            pixel_on       <= 1'b0;
            pixel_ch       <= '0;
        end else begin
            glyph_digit    <= sel_digit;
            glyph_row_addr <= in_region ? rel_y[3:0] : 4'd0;
            col1           <= in_region ? rel_x[3:0] : 4'd0;
            ch1            <= in_region ? line : 2'd0;
            in1            <= in_region;
            blank1         <= blank;
            pixel_on       <= glyph_row[col1] && in1 && !blank1;
            pixel_ch       <= ch1;
        end
    end

endmodule

// File: tb/tb_rgb_value_overlay.sv
// Scoreboard bench for rgb_value_overlay: stimulus pushes expected values
// tagged with the cycle they must appear in; a monitor compares them.
module tb_rgb_value_overlay;
    localparam logic [9:0] X0 = 10'd40;
    localparam logic [9:0] Y0 = 10'd24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount, vcount;
    logic        video_on;
    logic [3:0]  glyph_digit, glyph_row_addr;
    logic [0:15] glyph_row;
    logic        pixel_on;
    logic [1:0]  pixel_ch;
    bit          rom_ones = 1'b0;

    rgb_value_overlay_if ov();

    rgb_value_overlay #(.X0(X0), .Y0(Y0), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl(ov),
        .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .glyph_digit(glyph_digit), .glyph_row_addr(glyph_row_addr),
        .glyph_row(glyph_row), .pixel_on(pixel_on), .pixel_ch(pixel_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench glyph ROM: row = {digit, addr, ~digit, ~addr}, or all ones.
    function automatic logic [0:15] rom(input logic [3:0] d, input logic [3:0] a);
        logic [0:15] r;
        r = {d, a, ~d, ~a};
        return r;
    endfunction
    assign glyph_row = rom_ones ? 16'hFFFF : rom(glyph_digit, glyph_row_addr);

    typedef enum {K_BUSY, K_DONE, K_GD, K_GA, K_PO, K_PC} kind_t;
    typedef struct {
        int         at;
        kind_t      kind;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    logic [3:0] model [3][3];

    task automatic expect_at(input int at, input kind_t k, input logic [3:0] v, input string nm);
        exp_t e;
        e.at = at; e.kind = k; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        forever begin
            logic [3:0] act;
            @(negedge clk);
            #1;
            if (ov.done === 1'b1) done_seen++;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at <= cyc) begin
                    case (sb[i].kind)
                        K_BUSY:  act = {3'b0, ov.busy};
                        K_DONE:  act = {3'b0, ov.done};
                        K_GD:    act = glyph_digit;
                        K_GA:    act = glyph_row_addr;
                        K_PO:    act = {3'b0, pixel_on};
                        default: act = {2'b0, pixel_ch};
                    endcase
                    n_cmp++;
                    if (sb[i].at < cyc) begin
                        n_bad++;
                        $display("FAIL %s: expectation for cyc %0d missed (now %0d)", sb[i].name, sb[i].at, cyc);
                    end else if (act !== sb[i].val) begin
                        n_bad++;
                        $display("FAIL %s @cyc %0d: got %0d, want %0d", sb[i].name, cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    // Drive one scan position (relative to X0/Y0) for one cycle, called just
    // after a falling edge; glyph outputs expected one clock later, pixel two.
    task automatic scan_vec(input int rx, input int ry, input logic von,
                            input logic [3:0] gd, input logic [3:0] ga,
                            input logic po, input logic [1:0] pc, input string nm);
        hcount   = 10'(int'(X0) + rx);
        vcount   = 10'(int'(Y0) + ry);
        video_on = von;
        expect_at(cyc + 1, K_GD, gd, {nm, "_gd"});
        expect_at(cyc + 1, K_GA, ga, {nm, "_ga"});
        expect_at(cyc + 2, K_PO, {3'b0, po}, {nm, "_po"});
        expect_at(cyc + 2, K_PC, {2'b0, pc}, {nm, "_pc"});
        @(negedge clk);
    endtask

    task automatic scan_model(input int rx, input int ry, input logic von);
        logic [3:0] gd, ga, d;
        logic [0:15] row;
        logic po, blank, inr;
        logic [1:0] pc;
        int ln, ps;
        inr = von && rx >= 0 && rx < 48 && ry >= 0 && ry < 48;
        gd = 0; ga = 0; po = 0; pc = 0;
        if (inr) begin
            ln = ry / 16;
            ps = rx / 16;
            d  = model[ln][ps];
            blank = (ps == 0 && d == 0) || (ps == 1 && model[ln][0] == 0 && d == 0);
            gd  = d;
            ga  = 4'(ry % 16);
            row = rom_ones ? 16'hFFFF : rom(gd, ga);
            po  = !blank && row[rx % 16];
            pc  = 2'(ln);
        end
        scan_vec(rx, ry, von, gd, ga, po, pc, $sformatf("scan_x%0d_y%0d", rx, ry));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int base;
    int rows[8] = '{0, 3, 15, 16, 21, 32, 40, 47};

    initial begin
        rst_n = 1'b0;
        ov.load = 1'b0; ov.val_r = '0; ov.val_g = '0; ov.val_b = '0;
        hcount = X0 + 10'd5; vcount = Y0 + 10'd3; video_on = 1'b1;
        @(negedge clk);
        expect_at(cyc + 1, K_BUSY, 0, "rst_busy");
        expect_at(cyc + 1, K_DONE, 0, "rst_done");
        expect_at(cyc + 1, K_GD, 0, "rst_gd");
        expect_at(cyc + 1, K_GA, 0, "rst_ga");
        expect_at(cyc + 1, K_PO, 0, "rst_po");
        expect_at(cyc + 1, K_PC, 0, "rst_pc");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        video_on = 1'b0;
        @(negedge clk);

        // Conversion R=255 G=128 B=7; spec cycle n == cyc base+n.
        base = cyc;
        ov.load = 1'b1; ov.val_r = 8'd255; ov.val_g = 8'd128; ov.val_b = 8'd7;
        expect_at(base, K_BUSY, 0, "busy_c0");
        for (int n = 1; n <= 9; n++) expect_at(base + n, K_BUSY, 1, $sformatf("busy_c%0d", n));
        expect_at(base + 10, K_BUSY, 0, "busy_c10");
        expect_at(base + 11, K_BUSY, 0, "busy_after_commit_load");
        for (int n = 0; n <= 11; n++)
            expect_at(base + n, K_DONE, {3'b0, n == 9}, $sformatf("done_c%0d", n));
        @(negedge clk);
        ov.load = 1'b0;
        while (cyc < base + 4) @(negedge clk);
        ov.load = 1'b1; ov.val_r = 8'd0; ov.val_g = 8'd0; ov.val_b = 8'd0;
        @(negedge clk);
        ov.load = 1'b0;
        while (cyc < base + 9) @(negedge clk);
        ov.load = 1'b1;   // load during COMMIT must be ignored
        @(negedge clk);
        ov.load = 1'b0;
        while (cyc < base + 12) @(negedge clk);

        model = '{'{4'd2, 4'd5, 4'd5}, '{4'd1, 4'd2, 4'd8}, '{4'd0, 4'd0, 4'd7}};

        // ROM row for digit 2, addr 3 = 0010_0011_1101_1100 (index 0 leftmost)
        scan_vec(5, 3, 1'b1, 4'd2, 4'd3, 1'b0, 2'd0, "r_hund_x5");
        scan_vec(6, 3, 1'b1, 4'd2, 4'd3, 1'b1, 2'd0, "r_hund_x6");

        foreach (rows[k])
            for (int rx = -1; rx <= 49; rx++) scan_model(rx, rows[k], 1'b1);
        scan_model(10, 5, 1'b0);

        // B line with all-ones ROM: only the units digit (7) lights.
        rom_ones = 1'b1;
        for (int rx = 0; rx < 48; rx++)
            scan_vec(rx, 37, 1'b1, (rx >= 32) ? 4'd7 : 4'd0, 4'd5, rx >= 32, 2'd2,
                     $sformatf("b_line_x%0d", rx));
        scan_vec(48, 5, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, "out_x48");
        scan_vec(5, 5, 1'b0, 4'd0, 4'd0, 1'b0, 2'd0, "video_off");
        scan_vec(-1, 5, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, "out_xm1");
        scan_vec(5, 48, 1'b1, 4'd0, 4'd0, 1'b0, 2'd0, "out_y48");
        video_on = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during cycle 5 of a conversion.
        base = cyc;
        ov.load = 1'b1; ov.val_r = 8'd99; ov.val_g = 8'd200; ov.val_b = 8'd50;
        for (int n = 1; n <= 4; n++) expect_at(base + n, K_BUSY, 1, $sformatf("abort_busy_c%0d", n));
        for (int n = 5; n <= 12; n++) expect_at(base + n, K_BUSY, 0, $sformatf("abort_busy_c%0d", n));
        for (int n = 0; n <= 12; n++) expect_at(base + n, K_DONE, 0, $sformatf("abort_done_c%0d", n));
        @(negedge clk);
        ov.load = 1'b0;
        while (cyc < base + 5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        while (cyc < base + 13) @(negedge clk);

        model = '{'{4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0}};
        foreach (model[ln])
            for (int rx = 0; rx < 48; rx++) scan_model(rx, 16 * ln + 4, 1'b1);
        video_on = 1'b0;
        repeat (4) @(negedge clk);
        #2;

        n_cmp++;
        if (done_seen != 1) begin
            n_bad++;
            $display("FAIL done_count: got %0d pulses, want 1", done_seen);
        end
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
